// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_seq_pkg;

   // Sequencer phases: hold after hard reset, hold after soft request,
   // staged release, and fully released.
   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_SOFT  = 2'd1,
      ST_STAGE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Smallest width (at least 1) able to hold the values 0 .. n-1.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while (w < 32 && (64'd1 << w) < 64'(n)) begin
         w = w + 1;
      end
      return w;
   endfunction

   // Largest of three values, used to size the shared hold/soft/gap timers.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser.
// sync_ok_o rises after STAGES rising edges with rst_n_i high.
module reset_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   output logic sync_ok_o
);

   logic [STAGES-1:0] chain_q;

   // Shift ones into the chain; any rst_n_i low clears it immediately.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], 1'b1};
      end
   end

   assign sync_ok_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises the raw reset release, holds for a fixed
// time, then releases NUM_STAGES domain resets in order. A soft request in
// the released state re-runs the staged release without a hard reset.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYCLES = 32,
   parameter int unsigned NUM_STAGES  = 3,
   parameter int unsigned STAGE_GAP   = 4,
   parameter int unsigned SOFT_CYCLES = 8,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  soft_rst_i,
   output logic [NUM_STAGES-1:0] rst_o,
   output logic                  done_o,
   output logic [CNT_W-1:0]      soft_count_o
);

   localparam int unsigned TMR_W = cnt_width(max3(HOLD_CYCLES, STAGE_GAP, SOFT_CYCLES));
   localparam int unsigned IDX_W = cnt_width(NUM_STAGES);

   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] SOFT_LAST = TMR_W'(SOFT_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_e                  state_q, state_d;
   logic [TMR_W-1:0]        cnt_q, cnt_d;
   logic [TMR_W-1:0]        gap_q, gap_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_STAGES-1:0]   rst_q, rst_d;
   logic                    done_q, done_d;
   logic [CNT_W-1:0]        soft_cnt_q, soft_cnt_d;

   logic                    sync_ok;
   logic                    start_seq;
   logic [NUM_STAGES-1:0]   stage_hit;

   reset_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .sync_ok_o (sync_ok)
   );

   // One-hot decode of the stage currently being released.
   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_hit
      assign stage_hit[gi] = (idx_q == IDX_W'(gi));
   end

   // Next-state logic: hold/soft timers lead into the staged release;
   // rst bits are only ever cleared outside a full soft re-assertion.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      idx_d      = idx_q;
      rst_d      = rst_q;
      done_d     = done_q;
      soft_cnt_d = soft_cnt_q;
      start_seq  = 1'b0;

      case (state_q)
         ST_HOLD: begin
            if (sync_ok) begin
               if (cnt_q == HOLD_LAST) begin
                  start_seq = 1'b1;
               end else begin
                  cnt_d = cnt_q + TMR_W'(1);
               end
            end else begin
               cnt_d = '0;
            end
         end

         ST_SOFT: begin
            if (cnt_q == SOFT_LAST) begin
               start_seq = 1'b1;
            end else begin
               cnt_d = cnt_q + TMR_W'(1);
            end
         end

         ST_STAGE: begin
            if (gap_q == GAP_LAST) begin
               rst_d = rst_q & ~stage_hit;
               gap_d = '0;
               if (idx_q == IDX_LAST) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               gap_d = gap_q + TMR_W'(1);
            end
         end

         ST_DONE: begin
            if (soft_rst_i) begin
               rst_d   = '1;
               done_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_SOFT;
               if (soft_cnt_q != CNT_MAX) begin
                  soft_cnt_d = soft_cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_HOLD;
         end
      endcase

      // First release is common to the hard and soft paths.
      if (start_seq) begin
         rst_d[0] = 1'b0;
         cnt_d    = '0;
         if (NUM_STAGES == 1) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
         end else begin
            idx_d   = IDX_W'(1);
            gap_d   = '0;
            state_d = ST_STAGE;
         end
      end
   end

   // State and output registers, cleared asynchronously by the raw reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_HOLD;
         cnt_q      <= '0;
         gap_q      <= '0;
         idx_q      <= '0;
         rst_q      <= '1;
         done_q     <= 1'b0;
         soft_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         idx_q      <= idx_d;
         rst_q      <= rst_d;
         done_q     <= done_d;
         soft_cnt_q <= soft_cnt_d;
      end
   end

   assign rst_o        = rst_q;
   assign done_o       = done_q;
   assign soft_count_o = soft_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (defaults, and a
// NUM_STAGES=1/HOLD_CYCLES=1/CNT_W=2 corner) checked every cycle against a
// timeline model, plus literal checkpoints at the documented edges.
module tb_reset_sequencer;

   localparam int P_S[2]    = '{2, 2};
   localparam int P_H[2]    = '{32, 1};
   localparam int P_N[2]    = '{3, 1};
   localparam int P_G[2]    = '{4, 4};
   localparam int P_SOFT[2] = '{8, 8};
   localparam int P_CW[2]   = '{16, 2};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        soft_rst = 1'b0;
   logic [2:0]  rst0;
   logic        done0;
   logic [15:0] cnt0;
   logic [0:0]  rst1;
   logic        done1;
   logic [1:0]  cnt1;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;
   int ecount   = 0;

   // Model: edges since sequence start, which kind of start, and soft count.
   int t_m[2]         = '{0, 0};
   bit soft_mode_m[2] = '{0, 0};
   int cnt_m[2]       = '{0, 0};

   always #5 clk = ~clk;

   reset_sequencer u_dut0 (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .soft_rst_i   (soft_rst),
      .rst_o        (rst0),
      .done_o       (done0),
      .soft_count_o (cnt0)
   );

   reset_sequencer #(
      .SYNC_STAGES (2),
      .HOLD_CYCLES (1),
      .NUM_STAGES  (1),
      .STAGE_GAP   (4),
      .SOFT_CYCLES (8),
      .CNT_W       (2)
   ) u_dut1 (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .soft_rst_i   (soft_rst),
      .rst_o        (rst1),
      .done_o       (done1),
      .soft_count_o (cnt1)
   );

   // Expected reset vector: bit k is released once the timeline reaches
   // base + k*gap, base being S+H after a hard release or SOFT after a request.
   function automatic logic [2:0] exp_rst(int i);
      int base;
      logic [2:0] r;
      r = '0;
      base = soft_mode_m[i] ? P_SOFT[i] : (P_S[i] + P_H[i]);
      for (int k = 0; k < P_N[i]; k++) begin
         if (t_m[i] < base + k * P_G[i]) r[k] = 1'b1;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Edge index E<n> relative to the latest rst_n_i release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecount <= 0;
      else        ecount <= ecount + 1;
   end

   // Model timeline update.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            t_m[i]         <= 0;
            soft_mode_m[i] <= 1'b0;
            cnt_m[i]       <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (exp_rst(i) == 3'b000 && soft_rst) begin
               t_m[i]         <= 0;
               soft_mode_m[i] <= 1'b1;
               cnt_m[i]       <= (cnt_m[i] < (1 << P_CW[i]) - 1) ? cnt_m[i] + 1 : cnt_m[i];
            end else if (t_m[i] < 1000000) begin
               t_m[i] <= t_m[i] + 1;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc rst0",  {29'd0, rst0}, {29'd0, exp_rst(0)});
         chk("cyc done0", {31'd0, done0}, (exp_rst(0) == 3'b000) ? 1 : 0);
         chk("cyc cnt0",  {16'd0, cnt0}, cnt_m[0]);
         chk("cyc rst1",  {31'd0, rst1}, {29'd0, exp_rst(1)});
         chk("cyc done1", {31'd0, done1}, (exp_rst(1) == 3'b000) ? 1 : 0);
         chk("cyc cnt1",  {30'd0, cnt1}, cnt_m[1]);
      end
   end

   // Advance to 1 ns after edge E<n>; bounded so a stuck bench still ends.
   task automatic goto_edge(input int n);
      int guard;
      guard = 0;
      while (ecount < n && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (ecount != n) begin
         n_checks++;
         n_fail++;
         $display("FAIL goto_edge: reached E%0d expected E%0d", ecount, n);
      end
   endtask

   task automatic hard_release(input int low_cycles);
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (low_cycles) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b1;

      // Power-up, with an ignored soft pulse at E20.
      goto_edge(2);
      chk("p1 E2 rst1", rst1, 1);
      goto_edge(3);
      chk("p1 E3 rst1", rst1, 0);
      chk("p1 E3 done1", done1, 1);
      goto_edge(19);
      soft_rst = 1'b1;
      goto_edge(20);
      soft_rst = 1'b0;
      chk("p0 E20 cnt0", cnt0, 0);
      chk("p1 E20 cnt1", cnt1, 1);
      goto_edge(33);
      chk("p0 E33 rst0", rst0, 3'b111);
      goto_edge(34);
      chk("p0 E34 rst0", rst0, 3'b110);
      goto_edge(37);
      chk("p0 E37 rst0", rst0, 3'b110);
      goto_edge(38);
      chk("p0 E38 rst0", rst0, 3'b100);
      goto_edge(41);
      chk("p0 E41 done0", done0, 0);
      goto_edge(42);
      chk("p0 E42 rst0", rst0, 3'b000);
      chk("p0 E42 done0", done0, 1);
      chk("p0 E42 cnt0", cnt0, 0);

      // Single soft pulse accepted at T=E43.
      soft_rst = 1'b1;
      goto_edge(43);
      soft_rst = 1'b0;
      chk("s0 T rst0", rst0, 3'b111);
      chk("s0 T done0", done0, 0);
      chk("s0 T cnt0", cnt0, 1);
      chk("s1 T cnt1", cnt1, 2);
      goto_edge(50);
      chk("s0 T+7 rst0", rst0, 3'b111);
      goto_edge(51);
      chk("s0 T+8 rst0", rst0, 3'b110);
      chk("s1 T+8 done1", done1, 1);
      goto_edge(55);
      chk("s0 T+12 rst0", rst0, 3'b100);
      goto_edge(59);
      chk("s0 T+16 rst0", rst0, 3'b000);
      chk("s0 T+16 done0", done0, 1);

      // Soft request held high: re-accepted 17 clocks apart; corner saturates.
      soft_rst = 1'b1;
      goto_edge(60);
      chk("h0 E60 cnt0", cnt0, 2);
      chk("h0 E60 rst0", rst0, 3'b111);
      chk("h1 E60 cnt1", cnt1, 3);
      goto_edge(69);
      chk("h1 E69 cnt1", cnt1, 3);
      goto_edge(76);
      chk("h0 E76 done0", done0, 1);
      goto_edge(77);
      chk("h0 E77 cnt0", cnt0, 3);
      goto_edge(78);
      chk("h1 E78 cnt1", cnt1, 3);
      goto_edge(94);
      chk("h0 E94 cnt0", cnt0, 4);
      soft_rst = 1'b0;

      // Randomised traffic: soft requests at varying density, glitches and
      // longer hard resets; the per-cycle compare does the checking.
      for (int blk = 0; blk < 15; blk++) begin
         int dens;
         dens = $urandom_range(1, 8);
         for (int c = 0; c < 200; c++) begin
            int r;
            @(posedge clk);
            #2;
            soft_rst = ($urandom_range(0, 7) < dens) ? 1'b1 : 1'b0;
            r = $urandom_range(0, 399);
            if (r == 0) begin
               rst_n = 1'b0;
               #($urandom_range(1, 4));
               rst_n = 1'b1;
            end else if (r == 1) begin
               rst_n = 1'b0;
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #2 rst_n = 1'b1;
            end
         end
      end
      soft_rst = 1'b0;

      // Hard reset dropped mid-stage (rst_o=110, between E36 and E37).
      hard_release(3);
      goto_edge(33);
      chk("m0 E33 rst0", rst0, 3'b111);
      goto_edge(36);
      chk("m0 E36 rst0", rst0, 3'b110);
      #1 rst_n = 1'b0;
      #1;
      chk("m0 async rst0", rst0, 3'b111);
      chk("m0 async done0", done0, 0);
      chk("m0 async cnt0", cnt0, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      goto_edge(33);
      chk("m0 new E33 rst0", rst0, 3'b111);
      goto_edge(34);
      chk("m0 new E34 rst0", rst0, 3'b110);

      // Sub-cycle glitch restarts the whole sequence.
      goto_edge(40);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      goto_edge(33);
      chk("g0 E33 rst0", rst0, 3'b111);
      goto_edge(34);
      chk("g0 E34 rst0", rst0, 3'b110);
      goto_edge(42);
      chk("g0 E42 done0", done0, 1);

      @(negedge clk);
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
